pong_video_rx: RTL and testbench
================================

PONG_VIDEO_RX -- requirements
Module: pong_video_rx

Interface
REQ-001 Parameter X_BIT_WIDTH, default 9, SHALL set the width of the x counter, pix_x and line_len.
REQ-002 Parameter Y_BIT_WIDTH, default 8, SHALL set the width of the y counter, pix_y and frame_lines.
REQ-003 Parameter ACTIVE_WIDTH, default 128, SHALL set the last active x (inclusive).
REQ-004 Parameter ACTIVE_HEIGHT, default 64, SHALL set the last active y (inclusive).
REQ-005 clk  in  1  SHALL be the single clock; all logic SHALL be on its rising edge.
REQ-006 reset  in  1  SHALL be the asynchronous, active-high reset.
REQ-007 p_tick  in  1  SHALL be the pixel strobe; hsync, vsync and rgb SHALL be sampled only on clk edges where p_tick=1 (a "sample").
REQ-008 hsync  in  1  SHALL mark the last sample of a line.
REQ-009 vsync  in  1  SHALL mark the last line of a frame.
REQ-010 rgb  in  12  SHALL carry the incoming pixel colour.
REQ-011 pix_valid  out  1  SHALL be a one-cycle strobe for an active pixel.
REQ-012 pix_x, pix_y, pix_rgb  out  X_BIT_WIDTH, Y_BIT_WIDTH, 12  SHALL give the active pixel's coordinates and colour.
REQ-013 frame_start, frame_done, sync_err  out  1 each  SHALL be one-cycle pulses.
REQ-014 locked  out  1  SHALL be high in LOCKED only.
REQ-015 line_len, frame_lines, frame_sum  out  X_BIT_WIDTH, Y_BIT_WIDTH, 16  SHALL give the measured timing and the per-frame checksum.

Function
REQ-016 States SHALL be HUNT, MEASURE and LOCKED.
REQ-017 Frame boundary (FB): a sample with hsync=1 and vsync=1; the next sample SHALL be x=0, y=0.
REQ-018 vsync SHALL be evaluated only on hsync samples; vsync without hsync SHALL be ignored.
REQ-019 Counting: each non-hsync sample SHALL do x+1; each hsync sample SHALL do x=0 and y+1; each FB SHALL do x=0 and y=0.
REQ-020 HUNT: no counting; on FB SHALL go to MEASURE with x=0, y=0.
REQ-021 MEASURE: on the first hsync SHALL latch line_len = current x; on the next FB SHALL latch frame_lines = current y, go to LOCKED and pulse frame_start.
REQ-022 LOCKED: each hsync with x != line_len, or FB with y != frame_lines, or hsync with y = frame_lines but vsync=0, SHALL pulse sync_err, deassert locked and go to HUNT.
REQ-023 Overflow: x reaching all-ones without hsync, or y reaching all-ones without FB, in MEASURE or LOCKED SHALL pulse sync_err and go to HUNT.
REQ-024 In LOCKED, a sample with x <= ACTIVE_WIDTH and y <= ACTIVE_HEIGHT SHALL be active; pix_valid, pix_x, pix_y and pix_rgb SHALL be registered exactly 1 clk after the sample.
REQ-025 frame_sum: the running 16-bit wrap-around sum of zero-extended rgb over the frame's active pixels SHALL be presented, and frame_done pulsed, 1 clk after each FB in LOCKED; the accumulator SHALL then clear.
REQ-026 frame_start SHALL pulse 1 clk after each FB that leaves the FSM in LOCKED.
REQ-027 On an erroring FB, sync_err SHALL take priority: no frame_done and no frame_sum update.
REQ-028 The FSM SHALL ignore the p_tick=0 cycles: no state change and no strobes.

Reset
REQ-029 While reset is asserted: state=HUNT; x, y, accumulator, all outputs = 0.
REQ-030 Reset asserted mid-frame SHALL abort immediately with no pulses; after release, reacquisition SHALL restart from HUNT.

Verification
REQ-031 Source: 2:1 p_tick, 134 samples/line (hsync at x=133), 129 lines (vsync on y=128) -> line_len=133, frame_lines=128, locked rises with frame_start after the second FB.
REQ-032 Locked frame of constant rgb=12'h001 -> 129x65=8385 pix_valid strobes, first at (0,0), last at (128,64); frame_sum=16'h20C1.
REQ-033 Single line with hsync one sample early (x=132) -> one sync_err, locked=0; relock after two further FBs.
REQ-034 hsync held low for 600 samples -> sync_err when x reaches 511, state HUNT.
REQ-035 Reset pulsed at line 40 of a locked frame -> all outputs 0 next cycle; no frame_done for that frame.
REQ-036 p_tick stuck low for 1000 clks while locked -> no strobes and no state change; normal capture resumes when p_tick resumes.

Source files
------------

// File: rtl/pong_video_rx.sv
// Recovers pixel timing from a pong-style video stream (pixel strobe + end-of-line/end-of-frame marks),
// locks onto the measured line/frame geometry and emits active pixels plus a per-frame checksum.
module pong_video_rx #(
  parameter int X_BIT_WIDTH   = 9,
  parameter int Y_BIT_WIDTH   = 8,
  parameter int ACTIVE_WIDTH  = 128,
  parameter int ACTIVE_HEIGHT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   p_tick,
  input  logic                   hsync,
  input  logic                   vsync,
  input  logic [11:0]            rgb,
  output logic                   pix_valid,
  output logic [X_BIT_WIDTH-1:0] pix_x,
  output logic [Y_BIT_WIDTH-1:0] pix_y,
  output logic [11:0]            pix_rgb,
  output logic                   frame_start,
  output logic                   frame_done,
  output logic                   sync_err,
  output logic                   locked,
  output logic [X_BIT_WIDTH-1:0] line_len,
  output logic [Y_BIT_WIDTH-1:0] frame_lines,
  output logic [15:0]            frame_sum
);

  typedef enum logic [1:0] {HUNT, MEASURE, LOCKED} state_t;

  localparam logic [X_BIT_WIDTH-1:0] X_MAX = '1;
  localparam logic [Y_BIT_WIDTH-1:0] Y_MAX = '1;
  localparam logic [X_BIT_WIDTH-1:0] X_ONE = X_BIT_WIDTH'(1);
  localparam logic [Y_BIT_WIDTH-1:0] Y_ONE = Y_BIT_WIDTH'(1);

  state_t state, state_next;

  logic [X_BIT_WIDTH-1:0] x, x_next;
  logic [Y_BIT_WIDTH-1:0] y, y_next;
  logic [15:0]            acc, acc_next, acc_pix;
  logic                   have_len, have_len_next;

  logic                   pix_valid_next;
  logic [X_BIT_WIDTH-1:0] pix_x_next;
  logic [Y_BIT_WIDTH-1:0] pix_y_next;
  logic [11:0]            pix_rgb_next;
  logic                   frame_start_next, frame_done_next, sync_err_next;
  logic [X_BIT_WIDTH-1:0] line_len_next;
  logic [Y_BIT_WIDTH-1:0] frame_lines_next;
  logic [15:0]            frame_sum_next;

  logic fb, active, err;

  assign fb     = hsync & vsync;
  assign active = (32'(x) <= ACTIVE_WIDTH) && (32'(y) <= ACTIVE_HEIGHT);
  assign locked = (state == LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      acc         <= '0;
      have_len    <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      sync_err    <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      frame_sum   <= '0;
    end else begin
      x           <= x_next;
      y           <= y_next;
      acc         <= acc_next;
      have_len    <= have_len_next;
      pix_valid   <= pix_valid_next;
      pix_x       <= pix_x_next;
      pix_y       <= pix_y_next;
      pix_rgb     <= pix_rgb_next;
      frame_start <= frame_start_next;
      frame_done  <= frame_done_next;
      sync_err    <= sync_err_next;
      line_len    <= line_len_next;
      frame_lines <= frame_lines_next;
      frame_sum   <= frame_sum_next;
    end
  end

  always_comb begin
    state_next       = state;
    x_next           = x;
    y_next           = y;
    acc_next         = acc;
    acc_pix          = acc;
    have_len_next    = have_len;
    pix_valid_next   = 1'b0;
    pix_x_next       = pix_x;
    pix_y_next       = pix_y;
    pix_rgb_next     = pix_rgb;
    frame_start_next = 1'b0;
    frame_done_next  = 1'b0;
    sync_err_next    = 1'b0;
    line_len_next    = line_len;
    frame_lines_next = frame_lines;
    frame_sum_next   = frame_sum;
    err              = 1'b0;

    if (p_tick) begin
      case (state)
        HUNT: begin
          if (fb) begin
            state_next    = MEASURE;
            x_next        = '0;
            y_next        = '0;
            have_len_next = 1'b0;
          end
        end

        MEASURE: begin
          if (hsync && !have_len) begin
            line_len_next = x;
            have_len_next = 1'b1;
          end
          if (fb) begin
            frame_lines_next = y;
            state_next       = LOCKED;
            frame_start_next = 1'b1;
            x_next           = '0;
            y_next           = '0;
            acc_next         = '0;
          end else if (hsync) begin
            err    = (y == Y_MAX);
            x_next = '0;
            y_next = y + Y_ONE;
          end else begin
            err    = (x == X_MAX);
            x_next = x + X_ONE;
          end
        end

        LOCKED: begin
          // A line end is only legal at the measured length; the frame end only at the measured height.
          if (!hsync)                err = (x == X_MAX);
          else if (x != line_len)    err = 1'b1;
          else if (vsync)            err = (y != frame_lines);
          else                       err = (y == frame_lines) || (y == Y_MAX);

          if (active) begin
            pix_valid_next = 1'b1;
            pix_x_next     = x;
            pix_y_next     = y;
            pix_rgb_next   = rgb;
            acc_pix        = acc + {4'b0000, rgb};
          end
          acc_next = acc_pix;

          if (fb) begin
            frame_sum_next   = acc_pix;
            frame_done_next  = 1'b1;
            frame_start_next = 1'b1;
            acc_next         = '0;
            x_next           = '0;
            y_next           = '0;
          end else if (hsync) begin
            x_next = '0;
            y_next = y + Y_ONE;
          end else begin
            x_next = x + X_ONE;
          end
        end

        default: state_next = HUNT;
      endcase

      // Loss of sync overrides everything else decided for this sample.
      if (err) begin
        state_next       = HUNT;
        x_next           = '0;
        y_next           = '0;
        acc_next         = '0;
        have_len_next    = 1'b0;
        pix_valid_next   = 1'b0;
        pix_x_next       = pix_x;
        pix_y_next       = pix_y;
        pix_rgb_next     = pix_rgb;
        frame_start_next = 1'b0;
        frame_done_next  = 1'b0;
        frame_sum_next   = frame_sum;
        sync_err_next    = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pong_video_rx.sv
// Randomized scoreboard bench for pong_video_rx: a behavioural model predicts every output strobe,
// a free-running monitor compares what the receiver presents one clock after each sample.
module tb_pong_video_rx;

  localparam int XW    = 9;
  localparam int YW    = 8;
  localparam int AW    = 128;
  localparam int AH    = 64;
  localparam int XMAX  = (1 << XW) - 1;
  localparam int YMAX  = (1 << YW) - 1;

  localparam int K_PIX   = 0;
  localparam int K_DONE  = 1;
  localparam int K_START = 2;
  localparam int K_ERR   = 3;

  localparam int M_HUNT = 0;
  localparam int M_MEAS = 1;
  localparam int M_LOCK = 2;

  logic          clk, reset, p_tick, hsync, vsync;
  logic [11:0]   rgb;
  logic          pix_valid, frame_start, frame_done, sync_err, locked;
  logic [XW-1:0] pix_x, line_len;
  logic [YW-1:0] pix_y, frame_lines;
  logic [11:0]   pix_rgb;
  logic [15:0]   frame_sum;

  pong_video_rx #(
    .X_BIT_WIDTH(XW), .Y_BIT_WIDTH(YW), .ACTIVE_WIDTH(AW), .ACTIVE_HEIGHT(AH)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .frame_done(frame_done), .sync_err(sync_err), .locked(locked),
    .line_len(line_len), .frame_lines(frame_lines), .frame_sum(frame_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  int  pix_cnt  = 0;
  int  done_cnt = 0;
  int  last_sum = 0;
  int  last_px  = 0;
  int  last_py  = 0;

  // Reference model: line/frame position, learned geometry and running checksum.
  int  m_mode, m_col, m_row, m_len, m_lines, m_sum;
  bit  m_have_len;
  bit  exp_locked;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic push(input int kind, input int a, input int b, input int c);
    ev_t e;
    e.kind = kind; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_mode = M_HUNT; m_col = 0; m_row = 0; m_sum = 0; m_have_len = 0;
    exp_q.delete();
    exp_locked = 0;
  endtask

  task automatic model_sample(input bit h, input bit v, input int c);
    bit fb;
    bit bad;
    fb  = h && v;
    bad = 0;
    if (m_mode == M_HUNT) begin
      if (fb) begin
        m_mode = M_MEAS; m_col = 0; m_row = 0; m_have_len = 0;
      end
    end else if (m_mode == M_MEAS) begin
      if (h && !m_have_len) begin
        m_len = m_col; m_have_len = 1;
      end
      if (fb) begin
        m_lines = m_row;
        m_mode  = M_LOCK; m_col = 0; m_row = 0; m_sum = 0;
        push(K_START, m_len, m_lines, 0);
      end else if (h) begin
        if (m_row == YMAX) bad = 1;
        else begin m_col = 0; m_row++; end
      end else begin
        if (m_col == XMAX) bad = 1;
        else m_col++;
      end
    end else begin
      if (!h)                  bad = (m_col == XMAX);
      else if (m_col != m_len) bad = 1;
      else if (fb)             bad = (m_row != m_lines);
      else                     bad = (m_row == m_lines) || (m_row == YMAX);
      if (!bad) begin
        if (m_col <= AW && m_row <= AH) begin
          push(K_PIX, m_col, m_row, c);
          m_sum += c;
        end
        if (fb) begin
          push(K_DONE, m_sum % 65536, 0, 0);
          push(K_START, m_len, m_lines, 0);
          m_sum = 0; m_col = 0; m_row = 0;
        end else if (h) begin
          m_col = 0; m_row++;
        end else begin
          m_col++;
        end
      end
    end
    if (bad) begin
      push(K_ERR, 0, 0, 0);
      m_mode = M_HUNT; m_col = 0; m_row = 0; m_sum = 0; m_have_len = 0;
    end
    exp_locked = (m_mode == M_LOCK);
  endtask

  task automatic expect_event(input string name, input int kind, input int a, input int b, input int c);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("[TB] FAIL %s: got unexpected strobe, expected no strobe", name);
      return;
    end
    e = exp_q.pop_front();
    check({name, "_kind"}, kind, e.kind);
    if (kind == e.kind) begin
      check({name, "_a"}, a, e.a);
      check({name, "_b"}, b, e.b);
      check({name, "_c"}, c, e.c);
    end
  endtask

  // Monitor: everything the receiver presents after a clock edge is compared against the queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (pix_valid) begin
        pix_cnt++; last_px = int'(pix_x); last_py = int'(pix_y);
        expect_event("pixel", K_PIX, int'(pix_x), int'(pix_y), int'(pix_rgb));
      end
      if (frame_done) begin
        done_cnt++; last_sum = int'(frame_sum);
        expect_event("frame_done", K_DONE, int'(frame_sum), 0, 0);
      end
      if (frame_start) expect_event("frame_start", K_START, int'(line_len), int'(frame_lines), 0);
      if (sync_err)    expect_event("sync_err", K_ERR, 0, 0, 0);
      check("pending_events", exp_q.size(), 0);
      exp_q.delete();
      check("locked", int'(locked), int'(exp_locked));
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send_sample(input bit h, input bit v, input logic [11:0] c, input int gap);
    p_tick = 1'b1; hsync = h; vsync = v; rgb = c;
    model_sample(h, v, int'(c));
    @(negedge clk);
    p_tick = 1'b0; hsync = 1'($urandom); vsync = 1'($urandom); rgb = 12'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      p_tick = 1'b0; hsync = 1'($urandom); vsync = 1'($urandom); rgb = 12'($urandom);
      @(negedge clk);
    end
  endtask

  // gap < 0 picks a random 0..2 idle cycles per sample; color < 0 picks random colours.
  task automatic send_frame(input int hs_x, input int n_lines, input int bad_line,
                            input int stop_line, input int stall_line, input int gap, input int color);
    int hx, g;
    bit h, v;
    logic [11:0] c;
    for (int ly = 0; ly < n_lines && ly < stop_line; ly++) begin
      hx = (ly == bad_line) ? hs_x - 1 : hs_x;
      if (ly == stall_line) idle(1000);
      for (int lx = 0; lx <= hx; lx++) begin
        h = (lx == hx);
        v = h ? (ly == n_lines - 1) : ($urandom_range(0, 7) == 0);
        c = (color < 0) ? 12'($urandom) : 12'(color);
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        send_sample(h, v, c, g);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_valid"},   int'(pix_valid), 0);
    check({tag, "_pix_x"},       int'(pix_x), 0);
    check({tag, "_pix_y"},       int'(pix_y), 0);
    check({tag, "_pix_rgb"},     int'(pix_rgb), 0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
    check({tag, "_frame_done"},  int'(frame_done), 0);
    check({tag, "_sync_err"},    int'(sync_err), 0);
    check({tag, "_locked"},      int'(locked), 0);
    check({tag, "_line_len"},    int'(line_len), 0);
    check({tag, "_frame_lines"}, int'(frame_lines), 0);
    check({tag, "_frame_sum"},   int'(frame_sum), 0);
  endtask

  int done0;

  initial begin
    reset = 1'b1; p_tick = 1'b0; hsync = 1'b0; vsync = 1'b0; rgb = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Hunting: lone vsync and hsync-only samples must not start acquisition.
    for (int i = 0; i < 60; i++) send_sample(1'b0, 1'($urandom), 12'($urandom), 0);
    for (int i = 0; i < 5; i++)  send_sample(1'b1, 1'b0, 12'($urandom), 1);
    check("hunt_not_locked", int'(locked), 0);
    send_sample(1'b1, 1'b1, 12'h0, 1);

    // Full-size source at 2:1 pixel strobe: measure then lock.
    send_frame(133, 129, -1, 999, -1, 1, -1);
    check("acq_locked", int'(locked), 1);
    check("acq_line_len", int'(line_len), 133);
    check("acq_frame_lines", int'(frame_lines), 128);

    // Constant-colour frame covers the active window corners and checksum.
    pix_cnt = 0; done0 = done_cnt;
    send_frame(133, 129, -1, 999, -1, 0, 1);
    check("const_pix_count", pix_cnt, 8385);
    check("const_frame_sum", last_sum, 16'h20C1);
    check("const_last_x", last_px, 128);
    check("const_last_y", last_py, 64);
    check("const_done_count", done_cnt, done0 + 1);

    // Geometry change: loses lock, then relocks on the smaller timing.
    send_frame(11, 45, -1, 999, -1, 0, -1);
    check("geom_change_unlocked", int'(locked), 0);
    send_frame(11, 45, -1, 999, -1, -1, -1);
    check("small_locked", int'(locked), 1);
    check("small_line_len", int'(line_len), 11);
    check("small_frame_lines", int'(frame_lines), 44);
    repeat (3) send_frame(11, 45, -1, 999, -1, -1, -1);

    // Early hsync on one line.
    send_frame(11, 45, 7, 999, -1, 0, -1);
    check("early_hsync_unlocked", int'(locked), 0);
    send_frame(11, 45, -1, 999, -1, 0, -1);
    check("early_hsync_relocked", int'(locked), 1);

    // Extra line: hsync at the last line without vsync.
    send_frame(11, 46, -1, 999, -1, 0, -1);
    check("long_frame_unlocked", int'(locked), 0);
    send_frame(11, 45, -1, 999, -1, 0, -1);
    check("long_frame_relocked", int'(locked), 1);

    // Short frame: frame boundary one line early.
    send_frame(11, 44, -1, 999, -1, 0, -1);
    check("short_frame_unlocked", int'(locked), 0);
    send_frame(11, 45, -1, 999, -1, 0, -1);
    check("short_frame_measuring", int'(locked), 0);
    send_frame(11, 45, -1, 999, -1, 0, -1);
    check("short_frame_relocked", int'(locked), 1);

    // Missing hsync: x runs into its all-ones limit.
    send_frame(11, 45, -1, 3, -1, 0, -1);
    for (int i = 0; i < 600; i++) send_sample(1'b0, 1'($urandom), 12'($urandom), 0);
    check("overflow_unlocked", int'(locked), 0);
    repeat (2) send_frame(11, 45, -1, 999, -1, 0, -1);
    check("overflow_relocked", int'(locked), 1);

    // Reset at line 40 of a locked frame.
    done0 = done_cnt;
    send_frame(11, 45, -1, 40, -1, 0, -1);
    reset = 1'b1;
    model_reset();
    #1;
    check_all_zero("midframe_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_no_frame_done", done_cnt, done0);
    repeat (2) send_frame(11, 45, -1, 999, -1, 0, -1);
    check("reset_relocked", int'(locked), 1);

    // Pixel strobe stalls for 1000 clocks mid-frame.
    done0 = done_cnt;
    send_frame(11, 45, -1, 999, 20, 0, -1);
    check("stall_locked", int'(locked), 1);
    check("stall_frame_done", done_cnt, done0 + 1);
    send_frame(11, 45, -1, 999, -1, -1, -1);

    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
